fb_triple_buffer_sched: RTL and testbench



---
 rtl/fb_triple_buffer_sched.sv | 153 +++++++++++++++
 tb/tb_fb_triple_buffer_sched.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/fb_triple_buffer_sched.sv
// Triple-buffer scheduler handing frame base addresses to a stream writer and a scan-out reader.
// Optional FB_STATS_EN adds saturating drop_cnt / repeat_cnt statistics outputs.
module fb_triple_buffer_sched #(
    parameter int              ADDR_W      = 32,
    parameter logic [ADDR_W-1:0] BUF_BASE    = 'h0000_0000,
    parameter logic [ADDR_W-1:0] FRAME_BYTES = 'h0009_6000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              wr_req,
    input  logic              wr_done,
    output logic              wr_ack,
    output logic [ADDR_W-1:0] wr_base,
    input  logic              rd_req,
    output logic              rd_ack,
    output logic [ADDR_W-1:0] rd_base,
    output logic              pend_valid,
`ifdef FB_STATS_EN
    output logic [15:0]       drop_cnt,
    output logic [15:0]       repeat_cnt,
`endif
    output logic              wr_state_dbg
);

    // Handshake: every request is a one-cycle pulse; the matching ack is a
    // one-cycle pulse on the next cycle with its base already valid.

    typedef enum logic [0:0] {W_IDLE = 1'b0, W_ACTIVE = 1'b1} wstate_t;

    localparam logic [ADDR_W-1:0] BASE0 = BUF_BASE;
    localparam logic [ADDR_W-1:0] BASE1 = BUF_BASE + FRAME_BYTES;
    localparam logic [ADDR_W-1:0] BASE2 = BUF_BASE + FRAME_BYTES + FRAME_BYTES;

    function automatic logic [ADDR_W-1:0] base_of(input logic [1:0] idx);
        case (idx)
            2'd1:    base_of = BASE1;
            2'd2:    base_of = BASE2;
            default: base_of = BASE0;
        endcase
    endfunction

    wstate_t           st_q, st_d;
    logic [1:0]        w_idx_q, w_idx_d, r_idx_q, r_idx_d, p_idx_q, p_idx_d;
    logic              p_valid_q, p_valid_d;
    logic              wr_ack_q, wr_ack_d, rd_ack_q, rd_ack_d;
    logic [ADDR_W-1:0] wr_base_q, wr_base_d, rd_base_q, rd_base_d;
`ifdef FB_STATS_EN
    logic [15:0]       drop_cnt_q, drop_cnt_d, repeat_cnt_q, repeat_cnt_d;
`endif

    always_comb begin
        st_d      = st_q;
        w_idx_d   = w_idx_q;
        r_idx_d   = r_idx_q;
        p_idx_d   = p_idx_q;
        p_valid_d = p_valid_q;
        wr_ack_d  = 1'b0;
        rd_ack_d  = 1'b0;
        wr_base_d = wr_base_q;
        rd_base_d = rd_base_q;
`ifdef FB_STATS_EN
        drop_cnt_d   = drop_cnt_q;
        repeat_cnt_d = repeat_cnt_q;
`endif
        if (!enable) begin
            // Single-buffer mode: a frame started here must never complete into the ring.
            p_valid_d = 1'b0;
            if (wr_req) begin
                st_d      = W_IDLE;
                wr_ack_d  = 1'b1;
                wr_base_d = BASE0;
            end
            if (rd_req) begin
                rd_ack_d  = 1'b1;
                rd_base_d = BASE0;
            end
        end else begin
            // Order matters: writer completion, then reader swap, then writer restart.
            if (wr_done && st_q == W_ACTIVE) begin
`ifdef FB_STATS_EN
                if (p_valid_q && drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
`endif
                w_idx_d   = p_idx_q;
                p_idx_d   = w_idx_q;
                p_valid_d = 1'b1;
                st_d      = W_IDLE;
            end
            if (rd_req) begin
                if (p_valid_d) begin
                    r_idx_d   = p_idx_d;
                    p_idx_d   = r_idx_q;
                    p_valid_d = 1'b0;
                end else begin
`ifdef FB_STATS_EN
                    if (repeat_cnt_q != 16'hFFFF) repeat_cnt_d = repeat_cnt_q + 16'd1;
`endif
                end
                rd_ack_d  = 1'b1;
                rd_base_d = base_of(r_idx_d);
            end
            if (wr_req) begin
                st_d      = W_ACTIVE;
                wr_ack_d  = 1'b1;
                wr_base_d = base_of(w_idx_d);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st_q      <= W_IDLE;
            r_idx_q   <= 2'd0;
            w_idx_q   <= 2'd1;
            p_idx_q   <= 2'd2;
            p_valid_q <= 1'b0;
            wr_ack_q  <= 1'b0;
            rd_ack_q  <= 1'b0;
            wr_base_q <= BASE1;
            rd_base_q <= BASE0;
`ifdef FB_STATS_EN
            drop_cnt_q   <= 16'd0;
            repeat_cnt_q <= 16'd0;
`endif
        end else begin
            st_q      <= st_d;
            r_idx_q   <= r_idx_d;
            w_idx_q   <= w_idx_d;
            p_idx_q   <= p_idx_d;
            p_valid_q <= p_valid_d;
            wr_ack_q  <= wr_ack_d;
            rd_ack_q  <= rd_ack_d;
            wr_base_q <= wr_base_d;
            rd_base_q <= rd_base_d;
`ifdef FB_STATS_EN
            drop_cnt_q   <= drop_cnt_d;
            repeat_cnt_q <= repeat_cnt_d;
`endif
        end
    end

    assign wr_ack       = wr_ack_q;
    assign wr_base      = wr_base_q;
    assign rd_ack       = rd_ack_q;
    assign rd_base      = rd_base_q;
    assign pend_valid   = p_valid_q;
    assign wr_state_dbg = st_q;
`ifdef FB_STATS_EN
    assign drop_cnt     = drop_cnt_q;
    assign repeat_cnt   = repeat_cnt_q;
`endif

endmodule

// File: tb/tb_fb_triple_buffer_sched.sv
// Directed bench for fb_triple_buffer_sched; statistics checks compile in when FB_STATS_EN is defined.
module tb_fb_triple_buffer_sched;

    localparam logic [31:0] B0 = 32'h0000_0000;
    localparam logic [31:0] B1 = 32'h0009_6000;
    localparam logic [31:0] B2 = 32'h0012_C000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b1;
    logic        wr_req = 1'b0, wr_done = 1'b0, rd_req = 1'b0;
    logic        wr_ack, rd_ack, pend_valid, wr_state_dbg;
    logic [31:0] wr_base, rd_base;
`ifdef FB_STATS_EN
    logic [15:0] drop_cnt, repeat_cnt;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fb_triple_buffer_sched dut (
        .clk(clk), .reset(reset), .enable(enable),
        .wr_req(wr_req), .wr_done(wr_done), .wr_ack(wr_ack), .wr_base(wr_base),
        .rd_req(rd_req), .rd_ack(rd_ack), .rd_base(rd_base),
        .pend_valid(pend_valid),
`ifdef FB_STATS_EN
        .drop_cnt(drop_cnt), .repeat_cnt(repeat_cnt),
`endif
        .wr_state_dbg(wr_state_dbg)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive pulses for one clock edge, then sample #1 after that edge.
    task automatic step(input logic wq, input logic wd, input logic rq);
        wr_req = wq; wr_done = wd; rd_req = rq;
        @(posedge clk); #1;
        wr_req = 1'b0; wr_done = 1'b0; rd_req = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        reset = 1'b0;
    endtask

    initial begin
        @(posedge clk); #1;
        do_reset();
        chk("rst_wr_ack", wr_ack, 0);
        chk("rst_rd_ack", rd_ack, 0);
        chk("rst_wr_base", wr_base, B1);
        chk("rst_rd_base", rd_base, B0);
        chk("rst_pend", pend_valid, 0);
        chk("rst_state", wr_state_dbg, 0);
`ifdef FB_STATS_EN
        chk("rst_drop", drop_cnt, 0);
        chk("rst_repeat", repeat_cnt, 0);
`endif

        // First writer frame and a reader request with nothing pending.
        step(1'b1, 1'b0, 1'b0);
        chk("t1_wr_ack", wr_ack, 1);
        chk("t1_wr_base", wr_base, B1);
        chk("t1_state", wr_state_dbg, 1);
        step(1'b0, 1'b0, 1'b0);
        chk("t1_wr_ack_single", wr_ack, 0);
        step(1'b0, 1'b0, 1'b1);
        chk("t1_rd_ack", rd_ack, 1);
        chk("t1_rd_base", rd_base, B0);
`ifdef FB_STATS_EN
        chk("t1_repeat", repeat_cnt, 1);
`endif

        // Restart, complete, read the completed frame, next writer frame.
        step(1'b1, 1'b0, 1'b0);
        chk("t2_restart_base", wr_base, B1);
        step(1'b0, 1'b1, 1'b0);
        chk("t2_pend_after_done", pend_valid, 1);
        chk("t2_state_idle", wr_state_dbg, 0);
        step(1'b0, 1'b0, 1'b1);
        chk("t2_rd_base", rd_base, B1);
        chk("t2_pend_after_rd", pend_valid, 0);
        step(1'b1, 1'b0, 1'b0);
        chk("t2_wr_base", wr_base, B2);

        // Two frames with no reader: the older pending frame is dropped.
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        chk("t3_wr_base_mid", wr_base, B0);
        step(1'b0, 1'b1, 1'b0);
`ifdef FB_STATS_EN
        chk("t3_drop", drop_cnt, 1);
`endif
        step(1'b0, 1'b0, 1'b1);
        chk("t3_rd_base", rd_base, B0);
        step(1'b1, 1'b0, 1'b0);
        chk("t3_wr_base_after", wr_base, B2);

        // Same-cycle wr_done + rd_req, then same-cycle wr_req + wr_done.
        do_reset();
        step(1'b1, 1'b0, 1'b0);
        chk("t4_wr_base0", wr_base, B1);
        step(1'b0, 1'b1, 1'b1);
        chk("t4_rd_ack", rd_ack, 1);
        chk("t4_rd_base", rd_base, B1);
        chk("t4_pend", pend_valid, 0);
`ifdef FB_STATS_EN
        chk("t4_drop", drop_cnt, 0);
        chk("t4_repeat", repeat_cnt, 0);
`endif
        step(1'b1, 1'b0, 1'b0);
        chk("t4_wr_base1", wr_base, B2);
        step(1'b1, 1'b1, 1'b0);
        chk("t4_req_done_ack", wr_ack, 1);
        chk("t4_req_done_base", wr_base, B0);
        chk("t4_req_done_pend", pend_valid, 1);

        // Back-to-back reader requests each get an ack.
        step(1'b0, 1'b0, 1'b1);
        chk("t4_b2b_ack0", rd_ack, 1);
        chk("t4_b2b_base0", rd_base, B2);
        step(1'b0, 1'b0, 1'b1);
        chk("t4_b2b_ack1", rd_ack, 1);
        chk("t4_b2b_base1", rd_base, B2);
        step(1'b0, 1'b0, 1'b0);
        chk("t4_b2b_ack_off", rd_ack, 0);

        // Disabled mode: both sides get buffer 0, nothing moves.
        do_reset();
        enable = 1'b0;
        step(1'b1, 1'b0, 1'b0);
        chk("t5_wr_ack", wr_ack, 1);
        chk("t5_wr_base", wr_base, B0);
        step(1'b0, 1'b0, 1'b1);
        chk("t5_rd_ack", rd_ack, 1);
        chk("t5_rd_base", rd_base, B0);
        step(1'b0, 1'b1, 1'b0);
        chk("t5_pend", pend_valid, 0);
`ifdef FB_STATS_EN
        chk("t5_repeat_hold", repeat_cnt, 0);
`endif
        enable = 1'b1;
        step(1'b0, 1'b1, 1'b0);
        chk("t5_done_ignored", pend_valid, 0);
        step(1'b0, 1'b0, 1'b1);
        chk("t5_en_rd_base", rd_base, B0);
`ifdef FB_STATS_EN
        chk("t5_en_repeat", repeat_cnt, 1);
`endif

        // Reset while writer is active and requests arrive: acks suppressed.
        step(1'b1, 1'b0, 1'b0);
        reset = 1'b1;
        step(1'b1, 1'b1, 1'b1);
        reset = 1'b0;
        chk("t6_wr_ack", wr_ack, 0);
        chk("t6_rd_ack", rd_ack, 0);
        chk("t6_wr_base", wr_base, B1);
        chk("t6_rd_base", rd_base, B0);
        chk("t6_state", wr_state_dbg, 0);

`ifdef FB_STATS_EN
        // Long run of reader requests with no frames: repeat counter saturates.
        rd_req = 1'b1;
        repeat (70000) @(posedge clk);
        #1;
        rd_req = 1'b0;
        chk("t7_rd_ack", rd_ack, 1);
        chk("t7_repeat_sat", repeat_cnt, 16'hFFFF);
        step(1'b0, 1'b0, 1'b1);
        chk("t7_repeat_hold", repeat_cnt, 16'hFFFF);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
